// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: the internal shift-mode
// encoding and the mapping of shift levels onto pipeline stages.
package barrel_shifter_pkg;

    typedef enum logic [2:0] {
        SH_SLL = 3'd0,
        SH_SRL = 3'd1,
        SH_SRA = 3'd2,
        SH_ROL = 3'd3,
        SH_ROR = 3'd4
    } shift_mode_e;

    // Rotate takes priority over the arithmetic flag; arithmetic left is plain SLL.
    function automatic shift_mode_e decode_mode(input logic ro, input logic lr, input logic la);
        if (ro) begin
            return lr ? SH_ROR : SH_ROL;
        end
        if (lr) begin
            return la ? SH_SRA : SH_SRL;
        end
        return SH_SLL;
    endfunction

    // Level k is evaluated in stage floor(k*stages/levels); with stages <= levels
    // every stage receives at least one level.
    function automatic int stage_of_level(input int k, input int stages, input int levels);
        return (k * stages) / levels;
    endfunction

endpackage

// File: rtl/barrel_shift_level.sv
// One combinational level of the barrel shifter: conditionally shifts or rotates
// its input by 2^K according to the selected mode.
module barrel_shift_level
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             en,
    input  shift_mode_e      mode,
    input  logic             sign,
    output logic [WIDTH-1:0] data_out
);

    localparam int S = 1 << K;

    logic [WIDTH-1:0] shifted;

    // The sign input is the original operand MSB, so SRA fills correctly at every level.
    always_comb begin
        shifted = data_in;
        case (mode)
            SH_SLL:  shifted = {data_in[WIDTH-1-S:0], {S{1'b0}}};
            SH_SRL:  shifted = {{S{1'b0}}, data_in[WIDTH-1:S]};
            SH_SRA:  shifted = {{S{sign}}, data_in[WIDTH-1:S]};
            SH_ROL:  shifted = {data_in[WIDTH-1-S:0], data_in[WIDTH-1:WIDTH-S]};
            SH_ROR:  shifted = {data_in[S-1:0], data_in[WIDTH-1:S]};
            default: shifted = data_in;
        endcase
        data_out = en ? shifted : data_in;
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: log2(WIDTH) shift levels spread over STAGES register
// cuts, each stage with a valid/ready handshake and full backpressure.
module pipelined_barrel_shifter
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STAGES    = 2,
    parameter int TAG_WIDTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic                     LR,
    input  logic                     LA,
    input  logic                     RO,
    input  logic [$clog2(WIDTH)-1:0] W,
    input  logic [WIDTH-1:0]         A,
    input  logic [TAG_WIDTH-1:0]     TAG,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [WIDTH-1:0]         Y,
    output logic [TAG_WIDTH-1:0]     Y_TAG
);

    localparam int L = $clog2(WIDTH);

    // Stage inputs: stage 0 sees the ports, stage s sees register s-1.
    logic [WIDTH-1:0]     in_data [STAGES];
    logic [L-1:0]         in_w    [STAGES];
    shift_mode_e          in_mode [STAGES];
    logic                 in_sign [STAGES];
    logic [TAG_WIDTH-1:0] in_tag  [STAGES];
    logic [STAGES-1:0]    in_valid;

    logic [WIDTH-1:0]     stage_out [STAGES];
    logic [WIDTH-1:0]     level_out [L];

    logic [WIDTH-1:0]     data_reg [STAGES];
    logic [L-1:0]         w_reg    [STAGES];
    shift_mode_e          mode_reg [STAGES];
    logic                 sign_reg [STAGES];
    logic [TAG_WIDTH-1:0] tag_reg  [STAGES];
    logic [STAGES-1:0]    valid_reg;

    logic                 adv [STAGES+1];
    logic                 unused_ctrl;

    // Ready ripples from the consumer back to the input: a stage moves when it
    // is empty or the stage after it moves.
    always_comb begin
        adv[STAGES] = OUT_READY;
        for (int s = STAGES - 1; s >= 0; s--) begin
            adv[s] = !valid_reg[s] || adv[s+1];
        end
    end

    assign IN_READY  = adv[0];
    assign OUT_VALID = valid_reg[STAGES-1];
    assign Y         = data_reg[STAGES-1];
    assign Y_TAG     = tag_reg[STAGES-1];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : stage_in_g
            if (gi == 0) begin : port_g
                assign in_data[gi]  = A;
                assign in_w[gi]     = W;
                assign in_mode[gi]  = decode_mode(RO, LR, LA);
                assign in_sign[gi]  = A[WIDTH-1];
                assign in_tag[gi]   = TAG;
                assign in_valid[gi] = IN_VALID;
            end else begin : reg_g
                assign in_data[gi]  = data_reg[gi-1];
                assign in_w[gi]     = w_reg[gi-1];
                assign in_mode[gi]  = mode_reg[gi-1];
                assign in_sign[gi]  = sign_reg[gi-1];
                assign in_tag[gi]   = tag_reg[gi-1];
                assign in_valid[gi] = valid_reg[gi-1];
            end
        end

        for (genvar gi = 0; gi < L; gi++) begin : level_g
            localparam int ST = stage_of_level(gi, STAGES, L);
            logic [WIDTH-1:0] level_in;

            if (gi == 0 || stage_of_level(gi - 1, STAGES, L) != ST) begin : first_g
                assign level_in = in_data[ST];
            end else begin : chain_g
                assign level_in = level_out[gi-1];
            end

            barrel_shift_level #(
                .WIDTH (WIDTH),
                .K     (gi)
            ) u_level (
                .data_in  (level_in),
                .en       (in_w[ST][gi]),
                .mode     (in_mode[ST]),
                .sign     (in_sign[ST]),
                .data_out (level_out[gi])
            );

            if (gi == L - 1 || stage_of_level(gi + 1, STAGES, L) != ST) begin : last_g
                assign stage_out[ST] = level_out[gi];
            end
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_reg <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_reg[s] <= '0;
                w_reg[s]    <= '0;
                mode_reg[s] <= SH_SLL;
                sign_reg[s] <= 1'b0;
                tag_reg[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (adv[s]) begin
                    valid_reg[s] <= in_valid[s];
                    data_reg[s]  <= stage_out[s];
                    w_reg[s]     <= in_w[s];
                    mode_reg[s]  <= in_mode[s];
                    sign_reg[s]  <= in_sign[s];
                    tag_reg[s]   <= in_tag[s];
                end
            end
        end
    end

    // Already-consumed shift bits and the final stage's control fields are dead.
    always_comb begin
        unused_ctrl = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            unused_ctrl = unused_ctrl ^ (^w_reg[s]) ^ (^mode_reg[s]) ^ sign_reg[s];
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed-vector bench for pipelined_barrel_shifter (WIDTH=32, STAGES=2, TAG_WIDTH=4)
// with a result scoreboard, stall-stability monitor and latency checks.
module tb_pipelined_barrel_shifter;

    localparam int WIDTH     = 32;
    localparam int STAGES    = 2;
    localparam int TAG_WIDTH = 4;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 IN_VALID;
    logic                 IN_READY;
    logic                 LR, LA, RO;
    logic [4:0]           W;
    logic [WIDTH-1:0]     A;
    logic [TAG_WIDTH-1:0] TAG;
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic [WIDTH-1:0]     Y;
    logic [TAG_WIDTH-1:0] Y_TAG;

    int n_vec = 0;
    int n_bad = 0;

    logic [WIDTH+TAG_WIDTH-1:0] exp_q [$];
    logic                       prev_stall;
    logic [WIDTH-1:0]           held_y;
    logic [TAG_WIDTH-1:0]       held_tag;

    pipelined_barrel_shifter #(
        .WIDTH     (WIDTH),
        .STAGES    (STAGES),
        .TAG_WIDTH (TAG_WIDTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .LR        (LR),
        .LA        (LA),
        .RO        (RO),
        .W         (W),
        .A         (A),
        .TAG       (TAG),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Y         (Y),
        .Y_TAG     (Y_TAG)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present one operation and hold it until accepted; optionally queue its result.
    task automatic send(input logic ro, input logic lr, input logic la, input logic [4:0] w,
                        input logic [31:0] a, input logic [3:0] tg, input logic [31:0] exp_y,
                        input bit track);
        bit ok;
        ok = 1'b0;
        RO = ro; LR = lr; LA = la; W = w; A = a; TAG = tg;
        IN_VALID = 1'b1;
        if (track) exp_q.push_back({exp_y, tg});
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge CLK);
            ok = IN_READY;
            @(posedge CLK);
            #1;
        end
        if (!ok) check("accept timeout", {63'd0, ok}, 64'd1);
        IN_VALID = 1'b0;
        $display("sent ro=%0b lr=%0b la=%0b w=%0d a=%h tag=%h", ro, lr, la, w, a, tg);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge CLK);
            #1;
        end
        check("drain pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Output scoreboard plus hold check on stalled results.
    always @(negedge CLK) begin
        if (RST) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall out_valid", {63'd0, OUT_VALID}, 64'd1);
                check("stall y", {32'd0, Y}, {32'd0, held_y});
                check("stall y_tag", {60'd0, Y_TAG}, {60'd0, held_tag});
            end
            if (OUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) begin
                    check("spurious out_valid", {63'd0, OUT_VALID}, 64'd0);
                end else begin
                    logic [WIDTH+TAG_WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    check("result y", {32'd0, Y}, {32'd0, e[WIDTH+TAG_WIDTH-1:TAG_WIDTH]});
                    check("result y_tag", {60'd0, Y_TAG}, {60'd0, e[TAG_WIDTH-1:0]});
                    $display("recv y=%h tag=%h", Y, Y_TAG);
                end
            end
            prev_stall = OUT_VALID && !OUT_READY;
            held_y     = Y;
            held_tag   = Y_TAG;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp4 [8];
        exp4[0] = 32'h0;   exp4[1] = 32'h2;   exp4[2] = 32'h8;   exp4[3] = 32'h18;
        exp4[4] = 32'h40;  exp4[5] = 32'hA0;  exp4[6] = 32'h180; exp4[7] = 32'h380;

        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
        LR = 1'b0; LA = 1'b0; RO = 1'b0; W = '0; A = '0; TAG = '0;
        #3;
        check("reset out_valid", {63'd0, OUT_VALID}, 64'd0);
        check("reset y", {32'd0, Y}, 64'd0);
        check("reset y_tag", {60'd0, Y_TAG}, 64'd0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        #1 check("ready after reset", {63'd0, IN_READY}, 64'd1);
        @(posedge CLK); #1;

        // 1: SLL by 31 with latency check
        send(1'b0, 1'b0, 1'b0, 5'd31, 32'h00000001, 4'h5, 32'h80000000, 1'b1);
        @(negedge CLK);
        check("t1 valid early", {63'd0, OUT_VALID}, 64'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("t1 valid at latency", {63'd0, OUT_VALID}, 64'd1);
        drain();

        // 2: SRA then SRL back to back
        send(1'b0, 1'b1, 1'b1, 5'd4, 32'h80000000, 4'h1, 32'hF8000000, 1'b1);
        send(1'b0, 1'b1, 1'b0, 5'd4, 32'h80000000, 4'h2, 32'h08000000, 1'b1);
        @(negedge CLK);
        check("t2 sra valid", {63'd0, OUT_VALID}, 64'd1);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("t2 srl next cycle", {63'd0, OUT_VALID}, 64'd1);
        drain();

        // 3: rotates
        send(1'b1, 1'b1, 1'b0, 5'd4, 32'h000000F1, 4'h3, 32'h1000000F, 1'b1);
        send(1'b1, 1'b0, 1'b0, 5'd1, 32'h80000001, 4'h4, 32'h00000003, 1'b1);
        drain();

        // 4: streaming with backpressure on cycles 3..7
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(1'b0, 1'b0, 1'b0, 5'(i), 32'(i), 4'(i), exp4[i], 1'b1);
                end
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    OUT_READY = !(c >= 3 && c <= 7);
                    @(negedge CLK);
                    if (c == 3) check("t4 in_ready full", {63'd0, IN_READY}, 64'd0);
                    if (c == 6) check("t4 held valid", {63'd0, OUT_VALID}, 64'd1);
                    @(posedge CLK);
                    #1;
                end
            end
        join
        OUT_READY = 1'b1;
        drain();

        // 5: asynchronous reset with two ops in flight
        send(1'b0, 1'b0, 1'b0, 5'd1, 32'h00000001, 4'h9, 32'h0, 1'b0);
        send(1'b0, 1'b0, 1'b0, 5'd2, 32'h00000001, 4'hA, 32'h0, 1'b0);
        #2 RST = 1'b1;
        #1;
        check("t5 out_valid on reset", {63'd0, OUT_VALID}, 64'd0);
        check("t5 y on reset", {32'd0, Y}, 64'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("t5 ready after release", {63'd0, IN_READY}, 64'd1);
        repeat (4) begin
            @(negedge CLK);
            check("t5 no ghost", {63'd0, OUT_VALID}, 64'd0);
        end
        @(posedge CLK); #1;
        send(1'b0, 1'b1, 1'b0, 5'd8, 32'h12345678, 4'hC, 32'h00123456, 1'b1);
        @(negedge CLK);
        check("t5 valid early", {63'd0, OUT_VALID}, 64'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("t5 valid at latency", {63'd0, OUT_VALID}, 64'd1);
        drain();

        // 6: W=0 in every mode, arithmetic-left alias, W=31 boundaries
        send(1'b0, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 4'h0, 32'hDEADBEEF, 1'b1);
        send(1'b0, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 4'h1, 32'hDEADBEEF, 1'b1);
        send(1'b0, 1'b1, 1'b0, 5'd0, 32'hDEADBEEF, 4'h2, 32'hDEADBEEF, 1'b1);
        send(1'b0, 1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 4'h3, 32'hDEADBEEF, 1'b1);
        send(1'b1, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 4'h4, 32'hDEADBEEF, 1'b1);
        send(1'b1, 1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 4'h5, 32'hDEADBEEF, 1'b1);
        send(1'b0, 1'b0, 1'b1, 5'd8, 32'h000000F1, 4'h6, 32'h0000F100, 1'b1);
        send(1'b0, 1'b1, 1'b1, 5'd31, 32'h80000000, 4'h7, 32'hFFFFFFFF, 1'b1);
        send(1'b0, 1'b1, 1'b0, 5'd31, 32'h80000000, 4'h8, 32'h00000001, 1'b1);
        send(1'b1, 1'b1, 1'b0, 5'd31, 32'h00000001, 4'h9, 32'h00000002, 1'b1);
        send(1'b1, 1'b0, 1'b0, 5'd31, 32'h80000000, 4'hA, 32'h40000000, 1'b1);
        send(1'b0, 1'b1, 1'b1, 5'd3, 32'h7FFFFFF0, 4'hB, 32'h0FFFFFFE, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
